// File: rtl/rv_alu_pkg.sv
// Shared ALU opcode encoding and shift-amount width helpers for the rv_alu datapath.
package rv_alu_pkg;

  typedef enum logic [3:0] {
    AluAdd   = 4'b0000,
    AluSub   = 4'b0001,
    AluAnd   = 4'b0010,
    AluOr    = 4'b0011,
    AluXor   = 4'b0100,
    AluSlt   = 4'b0101,
    AluSltu  = 4'b0110,
    AluSll   = 4'b0111,
    AluSrl   = 4'b1000,
    AluSra   = 4'b1001,
    AluPassB = 4'b1010
  } alu_op_t;

  localparam int unsigned XlenDefault = 32;
  localparam int unsigned ShamtW      = $clog2(XlenDefault);

  function automatic int unsigned shamt_width(input int unsigned xlen);
    return $clog2(xlen);
  endfunction

endpackage

// File: rtl/rv_alu_shifter.sv
// Barrel shifter for SLL/SRL/SRA; only the low ShamtW bits of the amount are consumed.
module rv_alu_shifter #(
  parameter int unsigned Width  = 32,
  parameter int unsigned ShamtW = 5
) (
  input  logic [Width-1:0]  data_i,
  input  logic [ShamtW-1:0] shamt_i,
  input  logic              right_i,
  input  logic              arith_i,
  output logic [Width-1:0]  result_o
);

  always_comb begin
    result_o = '0;
    if (!right_i) begin
      result_o = data_i << shamt_i;
    end else if (arith_i) begin
      result_o = $unsigned($signed(data_i) >>> shamt_i);
    end else begin
      result_o = data_i >> shamt_i;
    end
  end

endmodule

// File: rtl/rv_alu.sv
// RV32I/RV64I integer ALU with branch compare flags.
// Define ALU_OUTREG_EN to register all outputs (1-cycle latency, sync active-low reset).
module rv_alu
  import rv_alu_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [3:0]      ALUControl,
  output logic [XLEN-1:0] ALUResult,
  output logic            Zero,
  output logic            LessThan,
  output logic            LessThanUnsigned
);

  localparam int unsigned S = shamt_width(XLEN);

  alu_op_t         op;
  logic [XLEN:0]   diff;
  logic [XLEN-1:0] shift_res;
  logic            shift_right;
  logic            shift_arith;
  logic [XLEN-1:0] result_d;
  logic            zero_d;
  logic            lt_d;
  logic            ltu_d;

  assign op = alu_op_t'(ALUControl);

  // One subtractor feeds SUB, SLT/SLTU and both compare flags; the carry out is a >= b unsigned.
  assign diff  = {1'b0, a} + {1'b0, ~b} + {{XLEN{1'b0}}, 1'b1};
  assign ltu_d = ~diff[XLEN];
  assign lt_d  = (a[XLEN-1] ^ b[XLEN-1]) ? a[XLEN-1] : diff[XLEN-1];

  assign shift_right = (op == AluSrl) || (op == AluSra);
  assign shift_arith = (op == AluSra);

  rv_alu_shifter #(
    .Width  (XLEN),
    .ShamtW (S)
  ) u_shifter (
    .data_i   (a),
    .shamt_i  (b[S-1:0]),
    .right_i  (shift_right),
    .arith_i  (shift_arith),
    .result_o (shift_res)
  );

  always_comb begin
    result_d = '0;
    case (op)
      AluAdd:   result_d = a + b;
      AluSub:   result_d = diff[XLEN-1:0];
      AluAnd:   result_d = a & b;
      AluOr:    result_d = a | b;
      AluXor:   result_d = a ^ b;
      AluSlt:   result_d = {{(XLEN-1){1'b0}}, lt_d};
      AluSltu:  result_d = {{(XLEN-1){1'b0}}, ltu_d};
      AluSll,
      AluSrl,
      AluSra:   result_d = shift_res;
      AluPassB: result_d = b;
      default:  result_d = '0;
    endcase
  end

  assign zero_d = (result_d == '0);

`ifdef ALU_OUTREG_EN
  logic [XLEN-1:0] result_q;
  logic            zero_q;
  logic            lt_q;
  logic            ltu_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      result_q <= '0;
      zero_q   <= 1'b0;
      lt_q     <= 1'b0;
      ltu_q    <= 1'b0;
    end else begin
      result_q <= result_d;
      zero_q   <= zero_d;
      lt_q     <= lt_d;
      ltu_q    <= ltu_d;
    end
  end

  assign ALUResult        = result_q;
  assign Zero             = zero_q;
  assign LessThan         = lt_q;
  assign LessThanUnsigned = ltu_q;
`else
  logic unused_clk_reset;
  assign unused_clk_reset = clk ^ reset;

  assign ALUResult        = result_d;
  assign Zero             = zero_d;
  assign LessThan         = lt_d;
  assign LessThanUnsigned = ltu_d;
`endif

endmodule

// File: tb/tb_rv_alu.sv
// Directed self-checking bench for rv_alu at XLEN=4; follows ALU_OUTREG_EN if defined.
module tb_rv_alu;

  localparam int unsigned XLEN = 4;

  logic            clk;
  logic            reset;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic [3:0]      ALUControl;
  logic [XLEN-1:0] ALUResult;
  logic            Zero;
  logic            LessThan;
  logic            LessThanUnsigned;

  int errors = 0;
  int checks = 0;

  rv_alu #(
    .XLEN (XLEN)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .a                (a),
    .b                (b),
    .ALUControl       (ALUControl),
    .ALUResult        (ALUResult),
    .Zero             (Zero),
    .LessThan         (LessThan),
    .LessThanUnsigned (LessThanUnsigned)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Apply inputs and wait until they are visible on the outputs.
  task automatic drive(input logic [3:0] op, input logic [3:0] va, input logic [3:0] vb);
    ALUControl = op;
    a          = va;
    b          = vb;
`ifdef ALU_OUTREG_EN
    @(posedge clk);
    #1;
`else
    #2;
`endif
  endtask

  task automatic test_reset;
    reset = 1'b0;
`ifdef ALU_OUTREG_EN
    drive(4'b1010, 4'b0110, 4'b1111);
    checks++;
    if (ALUResult !== 4'b0000) begin
      errors++; $display("FAIL reset_result got %b want 0000", ALUResult);
    end
    checks++;
    if (Zero !== 1'b0) begin
      errors++; $display("FAIL reset_zero got %b want 0", Zero);
    end
    checks++;
    if (LessThan !== 1'b0) begin
      errors++; $display("FAIL reset_lt got %b want 0", LessThan);
    end
    checks++;
    if (LessThanUnsigned !== 1'b0) begin
      errors++; $display("FAIL reset_ltu got %b want 0", LessThanUnsigned);
    end
    reset = 1'b1;
    drive(4'b0010, 4'b1100, 4'b1010);
    checks++;
    if (ALUResult !== 4'b1000) begin
      errors++; $display("FAIL release_and got %b want 1000", ALUResult);
    end
`else
    // Reset has no effect in the combinational build.
    drive(4'b0000, 4'b0011, 4'b0100);
    checks++;
    if (ALUResult !== 4'b0111) begin
      errors++; $display("FAIL reset_ignored got %b want 0111", ALUResult);
    end
    reset = 1'b1;
`endif
  endtask

  task automatic test_sub;
    drive(4'b0001, 4'b0101, 4'b0101);
    checks++;
    if ({ALUResult, Zero, LessThan, LessThanUnsigned} !== 7'b0000_1_0_0) begin
      errors++; $display("FAIL sub_equal got %b_%b%b%b want 0000_100", ALUResult, Zero,
                         LessThan, LessThanUnsigned);
    end
    drive(4'b0001, 4'b1000, 4'b0001);
    checks++;
    if ({ALUResult, Zero, LessThan, LessThanUnsigned} !== 7'b0111_0_1_0) begin
      errors++; $display("FAIL sub_neg got %b_%b%b%b want 0111_010", ALUResult, Zero,
                         LessThan, LessThanUnsigned);
    end
  endtask

  task automatic test_add;
    drive(4'b0000, 4'b0111, 4'b0001);
    checks++;
    if ({ALUResult, Zero} !== 5'b1000_0) begin
      errors++; $display("FAIL add_wrap got %b_%b want 1000_0", ALUResult, Zero);
    end
    drive(4'b0000, 4'b1111, 4'b0001);
    checks++;
    if ({ALUResult, Zero} !== 5'b0000_1) begin
      errors++; $display("FAIL add_carry got %b_%b want 0000_1", ALUResult, Zero);
    end
  endtask

  task automatic test_slt;
    drive(4'b0101, 4'b1111, 4'b0001);
    checks++;
    if ({ALUResult, LessThan} !== 5'b0001_1) begin
      errors++; $display("FAIL slt got %b_%b want 0001_1", ALUResult, LessThan);
    end
    drive(4'b0110, 4'b1111, 4'b0001);
    checks++;
    if ({ALUResult, LessThanUnsigned, Zero} !== 6'b0000_0_1) begin
      errors++; $display("FAIL sltu got %b_%b%b want 0000_01", ALUResult, LessThanUnsigned,
                         Zero);
    end
  endtask

  task automatic test_logic;
    drive(4'b0010, 4'b1100, 4'b1010);
    checks++;
    if (ALUResult !== 4'b1000) begin
      errors++; $display("FAIL and got %b want 1000", ALUResult);
    end
    drive(4'b0011, 4'b1100, 4'b1010);
    checks++;
    if (ALUResult !== 4'b1110) begin
      errors++; $display("FAIL or got %b want 1110", ALUResult);
    end
    drive(4'b0100, 4'b1100, 4'b1010);
    checks++;
    if (ALUResult !== 4'b0110) begin
      errors++; $display("FAIL xor got %b want 0110", ALUResult);
    end
    // Flags follow a/b regardless of opcode: 3 vs -7 signed, 3 vs 9 unsigned.
    drive(4'b1010, 4'b0011, 4'b1001);
    checks++;
    if ({ALUResult, LessThan, LessThanUnsigned} !== 6'b1001_0_1) begin
      errors++; $display("FAIL passb got %b_%b%b want 1001_01", ALUResult, LessThan,
                         LessThanUnsigned);
    end
  endtask

  task automatic test_shift;
    drive(4'b1001, 4'b1000, 4'b0101);
    checks++;
    if (ALUResult !== 4'b1100) begin
      errors++; $display("FAIL sra got %b want 1100", ALUResult);
    end
    drive(4'b1000, 4'b1000, 4'b0101);
    checks++;
    if (ALUResult !== 4'b0100) begin
      errors++; $display("FAIL srl got %b want 0100", ALUResult);
    end
    drive(4'b0111, 4'b1000, 4'b0101);
    checks++;
    if ({ALUResult, Zero} !== 5'b0000_1) begin
      errors++; $display("FAIL sll got %b_%b want 0000_1", ALUResult, Zero);
    end
    drive(4'b0111, 4'b0011, 4'b0010);
    checks++;
    if (ALUResult !== 4'b1100) begin
      errors++; $display("FAIL sll2 got %b want 1100", ALUResult);
    end
    drive(4'b1001, 4'b0111, 4'b0001);
    checks++;
    if (ALUResult !== 4'b0011) begin
      errors++; $display("FAIL sra_pos got %b want 0011", ALUResult);
    end
  endtask

  task automatic test_illegal;
    drive(4'b1111, 4'b1000, 4'b0101);
    checks++;
    if ({ALUResult, Zero} !== 5'b0000_1) begin
      errors++; $display("FAIL op1111 got %b_%b want 0000_1", ALUResult, Zero);
    end
    drive(4'b1011, 4'b0110, 4'b0011);
    checks++;
    if ({ALUResult, Zero} !== 5'b0000_1) begin
      errors++; $display("FAIL op1011 got %b_%b want 0000_1", ALUResult, Zero);
    end
  endtask

  initial begin
    reset      = 1'b0;
    a          = '0;
    b          = '0;
    ALUControl = '0;
    test_reset();
    test_sub();
    test_add();
    test_slt();
    test_logic();
    test_shift();
    test_illegal();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rv_alu.md
# rv_alu

Combinational integer ALU for the RV32I/RV64I datapath, sitting in the execute stage between the operand muxes and the writeback/branch logic. Performs arithmetic, logic, shift and set-less-than operations on two XLEN-bit operands selected by a 4-bit control code. It also produces the equal and less-than flags used by the branch unit. An optional output register stage can be compiled in.

## Interface
- XLEN, 32, operand/result width in bits; legal values are 4 and above.
- clk  in  1  clock; used only when the output register is compiled in.
- reset  in  1  synchronous, active-low reset; used only when the output register is compiled in.
- a  in  XLEN  operand A (rs1 or PC).
- b  in  XLEN  operand B (rs2 or immediate).
- ALUControl  in  4  operation select.
- ALUResult  out  XLEN  operation result.
- Zero  out  1  high when ALUResult == 0.
- LessThan  out  1  high when a < b, signed two's complement.
- LessThanUnsigned  out  1  high when a < b, unsigned.

## Operation
- ALUControl encoding:
  - 0000 ADD: a + b.
  - 0001 SUB: a − b.
  - 0010 AND.
  - 0011 OR.
  - 0100 XOR.
  - 0101 SLT: {0…0, signed a<b}.
  - 0110 SLTU: {0…0, unsigned a<b}.
  - 0111 SLL: a << b[S−1:0].
  - 1000 SRL: logical right shift.
  - 1001 SRA: arithmetic right shift, sign-filled.
  - 1010 PASSB: b (LUI).
- Codes 1011–1111 produce ALUResult = 0.
- For shifts, S = $clog2(XLEN); upper bits of b are ignored.
- All arithmetic is modulo 2^XLEN. No overflow output; carry out of the MSB is discarded.
- LessThan and LessThanUnsigned are computed from a and b for every opcode, independent of ALUControl.
- Zero always reflects the selected ALUResult. Under SUB, Zero is therefore equivalent to a == b.
- SLT/SLTU results and the flags share one subtractor/comparator.
- Output is a pure function of the current inputs; no internal state in the default build.

## Timing
- Default build: zero latency; outputs are combinational from a, b and ALUControl.
  - Outputs settle within the same cycle that the inputs change.
  - clk and reset have no effect.
- With ALU_OUTREG_EN:
  - All four outputs are registered on the rising edge of clk, giving a latency of 1 cycle.
  - When reset = 0 at a rising edge, ALUResult, Zero, LessThan and LessThanUnsigned all become 0.
  - Reset takes priority over new inputs in the same cycle.
  - Deasserting reset mid-stream causes the next edge to capture the then-current inputs.
- No handshake; a new operation may be issued every cycle.

## Configuration
- ALU_OUTREG_EN defined: one pipeline register on all outputs, with the synchronous active-low reset described in Timing.
- ALU_OUTREG_EN undefined: fully combinational; clk and reset are left unconnected internally.

## Structure
- Shared package rv_alu_pkg holds:
  - an enum typedef alu_op_t with the 4-bit codes above;
  - the localparam for the shift-amount width.
- The datapath callers import alu_op_t.
- One sub-module, rv_alu_shifter, is a natural split. It handles SLL/SRL/SRA with the direction and arithmetic controls.

## Test plan
All scenarios use XLEN = 4 in the default build unless noted; outputs are sampled after the inputs settle.
- SUB, a=0101, b=0101 → ALUResult 0000, Zero 1, LessThan 0, LessThanUnsigned 0.
- SUB, a=1000, b=0001 → ALUResult 0111, Zero 0, LessThan 1, LessThanUnsigned 0.
- ADD, a=0111, b=0001 → ALUResult 1000 (wrap), Zero 0. Also ADD, a=1111, b=0001 → ALUResult 0000, Zero 1.
- SLT, a=1111, b=0001 → ALUResult 0001. SLTU with the same operands → ALUResult 0000, LessThanUnsigned 0.
- Shifts, a=1000, b=0101 (shift amount 01):
  - SRA → 1100;
  - SRL → 0100;
  - SLL → 0000.
  - Also opcode 1111 → ALUResult 0000, Zero 1.
- ALU_OUTREG_EN build:
  - hold reset=0 for one edge → all outputs 0;
  - release reset and apply AND, a=1100, b=1010 → ALUResult 1000 one edge later.
